// File: rtl/serial_adder16_pkg.sv
// Shared definitions for the bit-serial adder: default word width and FSM state encodings.
package serial_adder16_pkg;

    localparam int unsigned HackWordWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through one full_adder
// cell and a registered carry. start/busy/done handshake; result held until next completion.
module serial_adder16
    import serial_adder16_pkg::*;
#(
    parameter int unsigned WIDTH = HackWordWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q, cout_q, overflow_q;
    logic             accept, last_bit;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] res_next;

    full_adder u_full_adder (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    assign last_bit = (cnt_q == LastCnt);
    assign res_next = {fa_s, res_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end
            end
            StRun: begin
                if (last_bit) state_d = StDone;
            end
            StDone: begin
                // A start in the done cycle chains straight into the next add.
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh_q  <= a;
                b_sh_q  <= b;
                carry_q <= cin;
                cnt_q   <= '0;
            end else if (state_q == StRun) begin
                res_sh_q <= res_next;
                a_sh_q   <= a_sh_q >> 1;
                b_sh_q   <= b_sh_q >> 1;
                carry_q  <= fa_co;
                cnt_q    <= cnt_q + CntW'(1);
                if (last_bit) begin
                    // carry_q is the carry into the MSB on this cycle.
                    sum_q      <= res_next;
                    cout_q     <= fa_co;
                    overflow_q <= carry_q ^ fa_co;
                end
            end
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder16.sv
// Self-checking bench for serial_adder16: directed table, multi-cycle corner sequences,
// and random adds against an arithmetic reference model.
module tb_serial_adder16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start, cin_in;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder16 #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a_in),
        .b        (b_in),
        .cin      (cin_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition; signed overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] tot;
        logic       ovf;
        tot = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        ovf = (x[W-1] == y[W-1]) && (tot[W-1] != x[W-1]);
        return {ovf, tot};
    endfunction

    // Drive start for one edge from off-edge time; returns #1 after the accept edge.
    task automatic start_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        start  = 1'b1;
        a_in   = x;
        b_in   = y;
        cin_in = ci;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat = edges after accept until done seen (0 on timeout); nbusy = busy samples before done.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    initial begin
        int            lat, nbusy, ndone;
        logic [W+1:0]  m;
        logic [W-1:0]  ra, rb;
        logic          rc;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        // Reset beats start.
        start = 1'b1;
        @(posedge clk);
        #1;
        check("reset_beats_start", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            start_add(vecs[v].a, vecs[v].b, vecs[v].ci);
            wait_done(lat, nbusy);
            check("tbl_latency", 32'(lat), 32'(W));
            check("tbl_busy_cycles", 32'(nbusy), 32'(W));
            check("tbl_sum", 32'(sum), 32'(vecs[v].exp_sum));
            check("tbl_cout", 32'(cout), 32'(vecs[v].exp_cout));
            check("tbl_ovf", 32'(overflow), 32'(vecs[v].exp_ovf));
            @(posedge clk);
            #1;
            check("tbl_done_one_cycle", 32'(done), 32'd0);
            check("tbl_sum_hold_idle", 32'(sum), 32'(vecs[v].exp_sum));
        end

        // Start pulsed mid-RUN must be ignored; previous result held during the run.
        start_add(16'h0003, 16'h0004, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("hold_during_run", 32'(sum), 32'(vecs[5].exp_sum));
        start = 1'b1;
        a_in  = 16'hAAAA;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, nbusy);
        check("midrun_latency", 32'(lat), 32'(W - 5));
        check("midrun_sum", 32'(sum), 32'h0007);
        ndone = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrun_extra_done", 32'(ndone), 32'd0);

        // Reset five cycles into RUN aborts the add with no done pulse.
        start_add(16'h1234, 16'h1111, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        ndone = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        start_add(16'h0010, 16'h0020, 1'b0);
        wait_done(lat, nbusy);
        check("after_abort_sum", 32'(sum), 32'h0030);

        // Back-to-back: start held in the DONE cycle.
        @(negedge clk);
        start_add(16'h0101, 16'h0202, 1'b0);
        wait_done(lat, nbusy);
        check("b2b_first_sum", 32'(sum), 32'h0303);
        start_add(16'h00FF, 16'h0001, 1'b0);
        check("b2b_busy_now", 32'(busy), 32'd1);
        check("b2b_sum_hold", 32'(sum), 32'h0303);
        wait_done(lat, nbusy);
        check("b2b_done_spacing", 32'(lat + 1), 32'(W + 1));
        check("b2b_sum", 32'(sum), 32'h0100);
        check("b2b_cout", 32'(cout), 32'd0);

        // Random adds vs. the arithmetic model.
        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            m  = model(ra, rb, rc);
            start_add(ra, rb, rc);
            wait_done(lat, nbusy);
            check("rand_latency", 32'(lat), 32'(W));
            check("rand_sum", 32'(sum), 32'(m[W-1:0]));
            check("rand_cout", 32'(cout), 32'(m[W]));
            check("rand_ovf", 32'(overflow), 32'(m[W+1]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
